// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard sequencer for a 5-stage MIPS core: load-use stalls, taken-branch
// flushes and multi-cycle data-memory freezes, plus stall/flush counters and a sticky timeout.
module pipe_hazard_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    localparam logic [7:0]       TIMER_MAX    = 8'hFF;
    localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_consumer;
    logic rt_consumer;
    logic load_use;
    logic mem_busy;
    logic branch_fire;

    always_comb begin
        rs_consumer = 1'b0;
        rt_consumer = 1'b0;
        case (id_op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
                rs_consumer = 1'b1;
                rt_consumer = 1'b1;
            end
            OP_ADDI, OP_LW, OP_BGTZ: rs_consumer = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((rs_consumer && (id_rs == ex_rt)) ||
                       (rt_consumer && (id_rt == ex_rt)));

    assign mem_busy = ((state_q == MEM_WAIT) || mem_req) && !mem_ack;

    // State register together with the registered timer, sticky flag and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            timer_q       <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Next state: an access already latched in MEM_WAIT ignores mem_req until acked
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_req && !mem_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ack) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d == RUN) begin
            timer_d = 8'd0;
        end else if ((state_q == MEM_WAIT) && !mem_ack && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 8'd1;
        end
    end

    assign mem_timeout_d = mem_timeout_q ||
                           ((state_q == MEM_WAIT) && !mem_ack && (timer_q == TIMEOUT_LAST));

    // Output decode: memory freeze outranks branch flush, which outranks load-use stall
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        freeze      = 1'b0;
        branch_fire = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            branch_fire = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_fire && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer: reset, load-use, false-hazard filtering,
// branch priority, memory freeze, timeout and reset during a memory wait.
module tb_pipe_hazard_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_sequencer #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_op          (id_op),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .freeze         (freeze),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        id_op           = 6'b111111;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        ex_memread      = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Packed control vector: {pc_write, ifid_write, ifid_flush, idex_flush, freeze}
    function automatic logic [4:0] ctrl();
        return {pc_write, ifid_write, ifid_flush, idex_flush, freeze};
    endfunction

    task automatic test_reset();
        tick();
        reset = 1'b1;
        idle_inputs();
        mem_req = 1'b1;
        ex_branch_taken = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 5'b00110) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00110", ctrl());
        end
        tick();
        tick();
        settle();
        n_checks++;
        if ({stall_cnt, flush_cnt, mem_timeout} !== {16'd0, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_regs: stall=%0d flush=%0d tmo=%b expected 0 0 0",
                     stall_cnt, flush_cnt, mem_timeout);
        end
        reset = 1'b0;
        idle_inputs();
        settle();
        n_checks++;
        if (ctrl() !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_release_ctrl: got %b expected 11000", ctrl());
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd8;
        id_op = 6'b000000; id_rs = 5'd8; id_rt = 5'd3;
        settle();
        n_checks++;
        if (ctrl() !== 5'b00010) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected 00010", ctrl());
        end
        tick();
        ex_memread = 1'b0;
        settle();
        n_checks++;
        if (ctrl() !== 5'b11000 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_release: ctrl=%b stall=%0d expected 11000 1", ctrl(), stall_cnt);
        end
        // rt-path hazard for sw
        ex_memread = 1'b1; ex_rt = 5'd12;
        id_op = 6'b101011; id_rs = 5'd1; id_rt = 5'd12;
        settle();
        n_checks++;
        if (ctrl() !== 5'b00010) begin
            n_fail++;
            $display("FAIL load_use_sw_rt: got %b expected 00010", ctrl());
        end
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if (stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL load_use_count: stall=%0d expected 2", stall_cnt);
        end
        $display("test_load_use done");
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd0;
        id_op = 6'b000000; id_rs = 5'd0; id_rt = 5'd0;
        settle();
        n_checks++;
        if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL no_hazard_r0: pc_write=%b idex_flush=%b expected 1 0", pc_write, idex_flush);
        end
        ex_rt = 5'd9; id_op = 6'b001000; id_rs = 5'd1; id_rt = 5'd9;
        settle();
        n_checks++;
        if (pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL no_hazard_addi_rt: pc_write=%b expected 1", pc_write);
        end
        id_op = 6'b000111; id_rs = 5'd2;
        settle();
        n_checks++;
        if (pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL no_hazard_bgtz_rt: pc_write=%b expected 1", pc_write);
        end
        id_op = 6'b111111; id_rs = 5'd9;
        settle();
        n_checks++;
        if (pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL no_hazard_unknown_op: pc_write=%b expected 1", pc_write);
        end
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL no_hazard_count: stall=%0d expected 0", stall_cnt);
        end
        $display("test_no_false_hazard done");
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd8;
        id_op = 6'b000100; id_rs = 5'd8; id_rt = 5'd4;
        ex_branch_taken = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 5'b11110) begin
            n_fail++;
            $display("FAIL branch_priority: got %b expected 11110", ctrl());
        end
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL branch_counts: flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
        end
        $display("test_branch_vs_load_use done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 5'b00001) begin
            n_fail++;
            $display("FAIL mem_wait_c1: got %b expected 00001", ctrl());
        end
        for (int i = 2; i <= 3; i++) begin
            tick();
            mem_req = 1'b0;
            ex_branch_taken = 1'b1;
            ex_memread = 1'b1; ex_rt = 5'd5; id_op = 6'b000000; id_rs = 5'd5;
            settle();
            n_checks++;
            if (ctrl() !== 5'b00001) begin
                n_fail++;
                $display("FAIL mem_wait_c%0d: got %b expected 00001", i, ctrl());
            end
        end
        tick();
        mem_ack = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 5'b11110) begin
            n_fail++;
            $display("FAIL mem_wait_ack: got %b expected 11110", ctrl());
        end
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if (freeze !== 1'b0 || stall_cnt !== 16'd3 || flush_cnt !== 16'd1 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_wait_after: freeze=%b stall=%0d flush=%0d tmo=%b expected 0 3 1 0",
                     freeze, stall_cnt, flush_cnt, mem_timeout);
        end
        $display("test_mem_wait done");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            mem_req = (i == 1);
            settle();
            n_checks++;
            if (freeze !== 1'b1 || mem_timeout !== (i >= 6)) begin
                n_fail++;
                $display("FAIL timeout_c%0d: freeze=%b tmo=%b expected 1 %b",
                         i, freeze, mem_timeout, (i >= 6));
            end
        end
        tick();
        mem_ack = 1'b1;
        settle();
        n_checks++;
        if (freeze !== 1'b0 || mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ack: freeze=%b tmo=%b expected 0 1", freeze, mem_timeout);
        end
        tick();
        idle_inputs();
        settle();
        n_checks++;
        if (mem_timeout !== 1'b1 || stall_cnt !== 16'd10 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: tmo=%b stall=%0d freeze=%b expected 1 10 0",
                     mem_timeout, stall_cnt, freeze);
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            mem_req = 1'b0;
        end
        settle();
        n_checks++;
        if (freeze !== 1'b1 || mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_pre: freeze=%b tmo=%b expected 1 1", freeze, mem_timeout);
        end
        tick();
        reset = 1'b1;
        settle();
        n_checks++;
        if (ctrl() !== 5'b00110) begin
            n_fail++;
            $display("FAIL mid_wait_reset_ctrl: got %b expected 00110", ctrl());
        end
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if (ctrl() !== 5'b11000 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_after: ctrl=%b stall=%0d flush=%0d tmo=%b expected 11000 0 0 0",
                     ctrl(), stall_cnt, flush_cnt, mem_timeout);
        end
        $display("test_reset_mid_wait done");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch_vs_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) around the main decoder.
- Issues PC/IF-ID write enables, bubble/flush controls and a global freeze for:
  - load-use hazards,
  - taken branches resolved in EX,
  - multi-cycle data-memory accesses (req/ack handshake).
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- MEM_TIMEOUT, 64, wait cycles without mem_ack before mem_timeout sets; range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_op  in  6  opcode of instruction in ID.
- id_rs  in  5  rs field in ID.
- id_rt  in  5  rt field in ID.
- ex_memread  in  1  EX holds lw.
- ex_rt  in  5  destination rt of the lw in EX.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  MEM holds lw/sw needing data memory.
- mem_ack  in  1  data memory completes access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_flush  out  1  ID/EX loads bubble (all control zero).
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with pc_write=0 since reset.
- flush_cnt  out  CNT_W  branch-flush events since reset.

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset gives RUN, wait timer 0, counters 0, mem_timeout 0.
- Control outputs are combinational from state and inputs, with zero latency. Counters, timer and mem_timeout are registered.
- While reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, freeze=0. Counters do not increment.
- Reset mid-wait: returns to RUN next edge, and clears the timer, counters and mem_timeout.
- Opcodes: 000000 R-type, 001000 addi, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 000111 bgtz.
- rs consumers: all seven opcodes. rt consumers: R-type, sw, beq, bne. Any other opcode never causes a hazard.
- mem_busy = (state==MEM_WAIT or mem_req) and not mem_ack.
- load_use = ex_memread and ex_rt!=0 and ((rs consumer and id_rs==ex_rt) or (rt consumer and id_rt==ex_rt)).
- Output priority, highest first:
  1. mem_busy: freeze=1, pc_write=0, ifid_write=0, both flushes 0. Branch and load-use are suppressed and re-evaluated once unfrozen.
  2. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. A simultaneous load_use is discarded because the dependent instruction is flushed.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. This gives exactly one bubble, since the condition clears when the bubble reaches EX.
  4. Otherwise: pc_write=1, ifid_write=1, flushes 0, freeze 0.
- FSM transitions:
  - RUN to MEM_WAIT: mem_req and not mem_ack.
  - mem_req with mem_ack in the same cycle: no freeze, stay in RUN.
  - MEM_WAIT to RUN: the cycle mem_ack=1. freeze=0 in that cycle.
  - In MEM_WAIT, mem_req is ignored; the access is already latched.
- Wait timer:
  - Increments each cycle in MEM_WAIT without mem_ack, saturates at 255, clears on entering RUN.
  - When timer==MEM_TIMEOUT-1 and mem_ack=0, mem_timeout sets the next edge.
  - mem_timeout stays set until reset. The FSM keeps waiting.
- stall_cnt: +1 each non-reset cycle with pc_write=0; saturates at all-ones.
- flush_cnt: +1 each cycle where priority 2 fires; saturates at all-ones.

Test Plan:
- Load-use: EX lw ex_rt=8, ID R-type rs=8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle (ex_memread=0) pc_write=1; stall_cnt=1.
- No false hazard, two cases:
  - EX lw ex_rt=0, ID rs=0 -> pc_write=1.
  - EX lw ex_rt=9, ID addi rt=9 -> pc_write=1 (addi rt is not a source).
- Branch vs load-use: ex_branch_taken=1 together with a load_use match -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ack low 3 cycles then high -> freeze=1 for 3 cycles, freeze=0 on the ack cycle, state back in RUN, stall_cnt=3. A branch asserted during the freeze produces no flush until unfrozen.
- Timeout: MEM_TIMEOUT=4, ack withheld 10 cycles -> mem_timeout rises after the 5th freeze cycle, stays 1 after ack, clears only on reset.
- Reset mid-wait: assert reset in MEM_WAIT -> next cycle RUN, counters 0, mem_timeout 0; after release with no hazards, pc_write=1.
